// File: rtl/host_interface_burst.sv
// Host-side GPIF interface: decodes the host opcode into device register strobes
// and runs counted burst reads/writes with optional register-address auto-increment.
module host_interface_burst #(
  parameter int DATA_W   = 16,
  parameter int EP_W     = 16,
  parameter int ADDR_W   = 16,
  parameter int TC_W     = 16,
  parameter int AUTO_INC = 0
) (
  input  logic              if_clock,
  input  logic              resetb,
  input  logic [2:0]        ctl,
  input  logic [3:0]        state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              rdy,
  output logic [EP_W-1:0]   diEpAddr,
  output logic [ADDR_W-1:0] diRegAddr,
  output logic [DATA_W-1:0] diRegDataIn,
  input  logic [DATA_W-1:0] diRegDataOut,
  output logic              diWrite,
  output logic              diRead,
  output logic              diReset,
  input  logic              rd_ready,
  input  logic              wr_ready,
  output logic              rd_done,
  output logic              wr_done
);

  localparam logic [3:0] OP_SETEP     = 4'd1;
  localparam logic [3:0] OP_SETREG    = 4'd2;
  localparam logic [3:0] OP_SETRVAL   = 4'd3;
  localparam logic [3:0] OP_RDDATA    = 4'd4;
  localparam logic [3:0] OP_RESETRVAL = 4'd5;
  localparam logic [3:0] OP_GETRVAL   = 4'd6;
  localparam logic [3:0] OP_RDTC      = 4'd7;
  localparam logic [3:0] OP_WRDATA    = 4'd8;
  localparam logic [3:0] OP_WRTC      = 4'd9;

  logic [3:0]        state_q, state_qq;
  logic [2:0]        ctl_q;
  logic [DATA_W-1:0] din_q;
  logic [TC_W-1:0]   rd_tc, wr_tc;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_rdy_q;
  logic              inc_pend;
  logic              stb, chg, rd_beat, wr_beat;
  logic              unused_ctl;

  assign stb        = ctl_q[1];
  assign unused_ctl = ^{ctl_q[2], ctl_q[0]};
  assign chg        = (state_q != state_qq);

  // Handshake: a burst beat happens only when the host strobes (stb), the device
  // is ready (rd_ready/wr_ready) and the remaining count is non-zero; rdy tells
  // the host whether its next strobe will be accepted.
  assign rd_beat = !chg && (state_q == OP_RDDATA) && stb && rd_ready && (rd_tc != '0);
  assign wr_beat = !chg && (state_q == OP_WRDATA) && stb && wr_ready && (wr_tc != '0);

  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= '0;
      state_qq    <= '0;
      ctl_q       <= '0;
      din_q       <= '0;
      rd_tc       <= '0;
      wr_tc       <= '0;
      rd_data_q   <= '0;
      rd_rdy_q    <= 1'b0;
      inc_pend    <= 1'b0;
      diEpAddr    <= '0;
      diRegAddr   <= '0;
      diRegDataIn <= '0;
      diWrite     <= 1'b0;
      diRead      <= 1'b0;
      diReset     <= 1'b0;
      rd_done     <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      state_q  <= state;
      state_qq <= state_q;
      ctl_q    <= ctl;
      din_q    <= data_in;
      diWrite  <= 1'b0;
      diRead   <= 1'b0;
      diReset  <= 1'b0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      rd_rdy_q <= 1'b0;
      inc_pend <= 1'b0;

      // Address bumps the cycle after a beat so the strobe sees the old address.
      if (inc_pend)
        diRegAddr <= diRegAddr + ADDR_W'(1);

      if (state_q == OP_RDDATA)
        rd_data_q <= diRegDataOut;

      if (!chg) begin
        rd_rdy_q <= (state_q == OP_RDDATA) && diRead;
        case (state_q)
          OP_SETEP:     if (stb) diEpAddr  <= din_q[EP_W-1:0];
          OP_SETREG:    if (stb) diRegAddr <= din_q[ADDR_W-1:0];
          OP_RDTC:      if (stb) rd_tc     <= din_q[TC_W-1:0];
          OP_WRTC:      if (stb) wr_tc     <= din_q[TC_W-1:0];
          OP_SETRVAL: begin
            if (stb && wr_ready) begin
              diWrite     <= 1'b1;
              diRegDataIn <= din_q;
            end
          end
          OP_RESETRVAL: diReset <= stb;
          OP_GETRVAL:   diRead  <= stb && rd_ready;
          OP_RDDATA: begin
            if (rd_beat) begin
              diRead   <= 1'b1;
              rd_tc    <= rd_tc - TC_W'(1);
              rd_done  <= (rd_tc == TC_W'(1));
              inc_pend <= (AUTO_INC != 0);
            end
          end
          OP_WRDATA: begin
            if (wr_beat) begin
              diWrite     <= 1'b1;
              diRegDataIn <= din_q;
              wr_tc       <= wr_tc - TC_W'(1);
              wr_done     <= (wr_tc == TC_W'(1));
              inc_pend    <= (AUTO_INC != 0);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Opcode 0 after reset keeps every combinational output low.
  always_comb begin
    rdy      = 1'b0;
    data_oe  = 1'b0;
    data_out = rd_data_q;
    if (!chg) begin
      case (state_q)
        OP_SETEP, OP_SETREG, OP_RDTC, OP_WRTC, OP_RESETRVAL: rdy = 1'b1;
        OP_SETRVAL: rdy = wr_ready;
        OP_GETRVAL: begin
          rdy      = rd_ready;
          data_oe  = 1'b1;
          data_out = diRegDataOut;
        end
        OP_RDDATA: begin
          rdy     = rd_rdy_q;
          data_oe = 1'b1;
        end
        OP_WRDATA: rdy = wr_ready && (wr_tc != '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_host_interface_burst.sv
// Bench for host_interface_burst: directed steps plus randomized bursts checked
// against a transaction-level model of the expected register writes and reads.
module tb_host_interface_burst;

  localparam logic [3:0] OP_SETEP     = 4'd1;
  localparam logic [3:0] OP_SETREG    = 4'd2;
  localparam logic [3:0] OP_SETRVAL   = 4'd3;
  localparam logic [3:0] OP_RDDATA    = 4'd4;
  localparam logic [3:0] OP_RESETRVAL = 4'd5;
  localparam logic [3:0] OP_GETRVAL   = 4'd6;
  localparam logic [3:0] OP_RDTC      = 4'd7;
  localparam logic [3:0] OP_WRDATA    = 4'd8;
  localparam logic [3:0] OP_WRTC      = 4'd9;

  logic        if_clock = 1'b0;
  logic        resetb;
  logic [2:0]  ctl;
  logic [3:0]  state;
  logic [15:0] data_in, data_out, diEpAddr, diRegAddr, diRegDataIn, diRegDataOut;
  logic        data_oe, rdy, diWrite, diRead, diReset, rd_ready, wr_ready, rd_done, wr_done;

  int checks = 0;
  int failures = 0;

  host_interface_burst #(
    .DATA_W(16), .EP_W(16), .ADDR_W(16), .TC_W(16), .AUTO_INC(1)
  ) dut (
    .if_clock(if_clock), .resetb(resetb), .ctl(ctl), .state(state),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .rdy(rdy),
    .diEpAddr(diEpAddr), .diRegAddr(diRegAddr), .diRegDataIn(diRegDataIn),
    .diRegDataOut(diRegDataOut), .diWrite(diWrite), .diRead(diRead), .diReset(diReset),
    .rd_ready(rd_ready), .wr_ready(wr_ready), .rd_done(rd_done), .wr_done(wr_done)
  );

  // clock / watchdog
  always #5 if_clock = ~if_clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // device model: returns successive words of a table, one per diRead
  logic [15:0] rd_words [0:255];
  int          rd_idx = 0;
  assign diRegDataOut = rd_words[rd_idx[7:0]];
  always @(posedge if_clock) if (diRead === 1'b1) rd_idx <= rd_idx + 1;

  // monitor: collects device-side transactions away from the active edge
  logic [31:0] obs_wr[$];
  logic [15:0] obs_rd_addr[$];
  logic [15:0] obs_rd_data[$];
  int          n_reset = 0, n_rd_done = 0, n_wr_done = 0;
  bit          cap_rd = 1'b0;

  always @(negedge if_clock) begin
    if (diWrite === 1'b1) obs_wr.push_back({diRegAddr, diRegDataIn});
    if (diRead === 1'b1) obs_rd_addr.push_back(diRegAddr);
    if (diReset === 1'b1) n_reset++;
    if (rd_done === 1'b1) n_rd_done++;
    if (wr_done === 1'b1) n_wr_done++;
    if (cap_rd && rdy === 1'b1) obs_rd_data.push_back(data_out);
  end

  // scoreboard state
  logic [31:0] exp_q[$];
  int          exp_rd_total = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge if_clock);
      #1;
    end
  endtask

  task automatic set_op(input logic [3:0] op);
    state = op;
    ctl   = 3'b000;
    tick(3);
  endtask

  task automatic pulse(input logic [15:0] val);
    data_in = val;
    ctl     = 3'b010;
    tick(1);
    ctl = 3'b000;
    tick(2);
  endtask

  task automatic load(input logic [3:0] op, input logic [15:0] val);
    set_op(op);
    pulse(val);
  endtask

  task automatic wr_burst(input logic [15:0] start, input int n, input logic [7:0] stall);
    int          base, done0;
    logic [15:0] w;
    load(OP_SETREG, start);
    load(OP_WRTC, 16'(n));
    set_op(OP_WRDATA);
    wr_ready = 1'b1;
    base  = obs_wr.size();
    done0 = n_wr_done;
    exp_q.delete();
    check("wr_rdy_start", rdy, n != 0);
    check("wr_oe", data_oe, 1'b0);
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom_range(0, 16'hFFFF));
      if (stall[i]) begin
        wr_ready = 1'b0;
        data_in  = w;
        ctl      = 3'b010;
        tick(1);
        ctl = 3'b000;
        check("wr_rdy_stall", rdy, 1'b0);
        tick(1);
        wr_ready = 1'b1;
        tick(1);
      end
      pulse(w);
      exp_q.push_back({16'(start + 16'(i)), w});
    end
    tick(1);
    check("wr_count", obs_wr.size() - base, n);
    for (int i = 0; i < n && base + i < obs_wr.size(); i++)
      check("wr_addr_data", obs_wr[base + i], exp_q[i]);
    check("wr_done_cnt", n_wr_done - done0, n != 0);
    check("wr_end_addr", diRegAddr, 16'(start + 16'(n)));
    check("wr_rdy_empty", rdy, 1'b0);
    pulse(16'h5A5A);
    check("wr_no_extra", obs_wr.size() - base, n);
  endtask

  task automatic rd_burst(input logic [15:0] start, input int n, input bit bp);
    int base_a, base_d, done0, got;
    load(OP_SETREG, start);
    load(OP_RDTC, 16'(n));
    set_op(OP_RDDATA);
    base_a = obs_rd_addr.size();
    base_d = obs_rd_data.size();
    done0  = n_rd_done;
    cap_rd = 1'b1;
    check("rd_oe", data_oe, 1'b1);
    ctl = 3'b010;
    for (int c = 0; c < 200; c++) begin
      got = obs_rd_addr.size() - base_a;
      if (c >= n + 3 && got >= n) break;
      rd_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick(1);
    end
    ctl      = 3'b000;
    rd_ready = 1'b1;
    tick(4);
    cap_rd = 1'b0;
    check("rd_count", obs_rd_addr.size() - base_a, n);
    check("rd_rdy_count", obs_rd_data.size() - base_d, n);
    for (int i = 0; i < n && base_a + i < obs_rd_addr.size(); i++)
      check("rd_addr", obs_rd_addr[base_a + i], 16'(start + 16'(i)));
    for (int i = 0; i < n && base_d + i < obs_rd_data.size(); i++)
      check("rd_data", obs_rd_data[base_d + i], rd_words[(exp_rd_total + i) % 256]);
    check("rd_done_cnt", n_rd_done - done0, n != 0);
    exp_rd_total += n;
  endtask

  initial begin
    int          base, base_a, done0;
    logic [3:0]  bad_op;

    for (int i = 0; i < 256; i++) rd_words[i] = 16'($urandom_range(0, 16'hFFFF));
    resetb   = 1'b0;
    ctl      = 3'b000;
    state    = 4'd0;
    data_in  = 16'h0;
    rd_ready = 1'b1;
    wr_ready = 1'b1;

    // reset state
    tick(3);
    check("rst_data_out", data_out, 16'h0);
    check("rst_flags", {data_oe, rdy, diWrite, diRead, diReset, rd_done, wr_done}, 7'h0);
    check("rst_addrs", {diEpAddr, diRegAddr}, 32'h0);
    check("rst_wdata", diRegDataIn, 16'h0);
    resetb = 1'b1;
    tick(2);

    // reset mid-burst aborts and loses the count
    load(OP_WRTC, 16'd5);
    set_op(OP_WRDATA);
    check("pre_rst_rdy", rdy, 1'b1);
    data_in = 16'h1234;
    ctl     = 3'b010;
    tick(2);
    #2 resetb = 1'b0;
    #1;
    check("async_rst_flags", {data_oe, rdy, diWrite, diRead, diReset, rd_done, wr_done}, 7'h0);
    check("async_rst_data", {data_out, diRegDataIn}, 32'h0);
    check("async_rst_addrs", {diEpAddr, diRegAddr}, 32'h0);
    tick(2);
    resetb = 1'b1;
    ctl    = 3'b000;
    tick(3);
    base  = obs_wr.size();
    done0 = n_wr_done;
    ctl   = 3'b010;
    tick(4);
    check("post_rst_rdy", rdy, 1'b0);
    ctl = 3'b000;
    tick(2);
    check("post_rst_no_write", obs_wr.size() - base, 0);
    check("post_rst_no_done", n_wr_done - done0, 0);

    // single register accesses
    load(OP_SETEP, 16'h0012);
    check("setep", diEpAddr, 16'h0012);
    load(OP_SETREG, 16'h0100);
    check("setreg", diRegAddr, 16'h0100);
    set_op(OP_SETRVAL);
    base = obs_wr.size();
    check("setrval_rdy", rdy, 1'b1);
    pulse(16'hBEEF);
    check("setrval_count", obs_wr.size() - base, 1);
    if (obs_wr.size() > base) check("setrval_word", obs_wr[base], {16'h0100, 16'hBEEF});
    check("setrval_no_inc", diRegAddr, 16'h0100);
    set_op(OP_RESETRVAL);
    check("resetrval_rdy", rdy, 1'b1);
    done0 = n_reset;
    pulse(16'h0);
    check("resetrval_pulse", n_reset - done0, 1);

    // fixed burst read of three known words
    for (int i = 0; i < 3; i++) rd_words[(exp_rd_total + i) % 256] = 16'h00A0 + 16'(i);
    rd_burst(16'h0100, 3, 1'b0);

    // burst write across the address wrap with a two-cycle device stall
    wr_burst(16'hFFFE, 4, 8'b0000_0100);

    // opcode switch mid-burst keeps the remaining read count
    load(OP_RDTC, 16'd5);
    set_op(OP_RDDATA);
    base_a = obs_rd_addr.size();
    done0  = n_rd_done;
    ctl    = 3'b010;
    tick(2);
    ctl = 3'b000;
    tick(3);
    check("sw_first_reads", obs_rd_addr.size() - base_a, 2);
    check("sw_oe_before", data_oe, 1'b1);
    exp_rd_total += 2;
    state = OP_GETRVAL;
    tick(1);
    check("sw_cleared_oe", data_oe, 1'b0);
    check("sw_cleared_rdy", rdy, 1'b0);
    tick(1);
    check("sw_cleared_read", diRead, 1'b0);
    check("getrval_oe", data_oe, 1'b1);
    check("getrval_rdy", rdy, 1'b1);
    check("getrval_data", data_out, rd_words[exp_rd_total % 256]);
    tick(1);
    pulse(16'h0);
    check("getrval_reads", obs_rd_addr.size() - base_a, 3);
    exp_rd_total += 1;
    set_op(OP_RDDATA);
    ctl = 3'b010;
    tick(6);
    ctl = 3'b000;
    tick(3);
    check("sw_resume_reads", obs_rd_addr.size() - base_a, 6);
    check("sw_done_once", n_rd_done - done0, 1);
    exp_rd_total += 3;

    // unknown opcodes stay silent
    for (int k = 0; k < 3; k++) begin
      bad_op = (k == 0) ? 4'hF : ((k == 1) ? 4'h0 : 4'($urandom_range(10, 15)));
      set_op(bad_op);
      base   = obs_wr.size();
      base_a = obs_rd_addr.size();
      for (int c = 0; c < 6; c++) begin
        ctl = (c % 2 == 0) ? 3'b010 : 3'b000;
        data_in = 16'($urandom_range(0, 16'hFFFF));
        tick(1);
        check("idle_outputs", {rdy, data_oe, diWrite, diRead, diReset, rd_done, wr_done}, 7'h0);
      end
      ctl = 3'b000;
      tick(2);
      check("idle_no_access", (obs_wr.size() - base) + (obs_rd_addr.size() - base_a), 0);
    end

    // randomized bursts, including zero-length ones
    for (int r = 0; r < 4; r++) begin
      wr_burst(($urandom_range(0, 1) != 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                           : 16'($urandom_range(0, 16'hFFFF)),
               $urandom_range(0, 6), 8'($urandom_range(0, 255)));
      rd_burst(16'($urandom_range(0, 16'hFFFF)), $urandom_range(0, 6), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
